mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline: sits between the execute stage and `wb_stage` and drives `wb_stage`'s `reg_data` / `reg_addr` / `reg_write` inputs. Passes ALU results straight through. Performs loads and stores over a single-outstanding req/ack data-memory port, with byte-lane alignment and sign extension. Stalls upstream while a bus access is in flight.

## Interface
- `ADDR_WIDTH`, 32: data-memory byte-address width. Fixed data width of 32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute-stage result valid this cycle.
- `in_ready` out 1: stage accepts `in_valid` this cycle.
- `alu_result` in 32: register result or memory byte address.
- `store_data` in 32: unaligned store value, in the low bits.
- `mem_op` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `mem_read` / `mem_write` in 1 each: load / store request.
- `rd_addr` in 5, `rd_write` in 1: destination register and write enable.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_WIDTH, `dmem_wdata` out 32, `dmem_be` out 4: bus request.
- `dmem_ack` in 1, `dmem_rdata` in 32: bus completion and read data, valid when `dmem_ack` is high.
- `reg_data` out 32, `reg_addr` out 5, `reg_write` out 1: to `wb_stage`.
- `misalign_trap` out 1: present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, ACCESS. `in_ready` = (state == IDLE).
- **Pass-through.** IDLE with `in_valid` and no memory op:
  - next edge `reg_data` = `alu_result`, `reg_addr` = `rd_addr`.
  - `reg_write` = `rd_write` and `rd_addr` != 0.
- **Memory op.** IDLE with `in_valid` and (`mem_read` or `mem_write`):
  - latch the op; next edge enter ACCESS.
  - `dmem_req` = 1; `reg_write` = 0 (bubble).
- **ACCESS.** `dmem_*` held stable until `dmem_ack`.
  - On the ack edge: return to IDLE and drop `dmem_req`.
  - Load: `reg_data` = extracted value, `reg_write` = `rd_write` and `rd_addr` != 0.
  - Store: `reg_write` = 0.
- **Read/write priority.** `mem_read` and `mem_write` both high: treated as a store.
- **Illegal `mem_op`** (011, 110, 111): treated as a word op.
- **Bus address.** `dmem_addr` = address with bits [1:0] forced to 0; `off` = `alu_result[1:0]`.
- **Store lanes.**
  - Byte: `dmem_wdata` = byte replicated 4x, `dmem_be` = 0001 << `off`.
  - Half: half replicated 2x, `dmem_be` = 0011 << (2·`off[1]`).
  - Word: `dmem_be` = 1111.
  - Loads drive `dmem_be` = 1111 and `dmem_we` = 0.
- **Load extract.**
  - Byte = `dmem_rdata[8·off +: 8]`; half = `dmem_rdata[16·off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Idle-cycle outputs.** Cycles with no `in_valid` in IDLE: `reg_write` = 0; `reg_data` / `reg_addr` hold.
- **Early ack.** `dmem_ack` outside ACCESS is ignored.

## Timing
- Reset (async assert): state IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be` = 0.
  - `reg_data`, `reg_addr`, `reg_write`, `misalign_trap` = 0; `in_ready` = 1.
- Reset mid-ACCESS: request abandoned and `dmem_req` drops asynchronously; no writeback produced.
- Pass-through latency: 1 cycle, full throughput.
- Memory op latency: 1 + N cycles, where N ≥ 1 is the number of ACCESS cycles up to and including the ack.
  - Zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles.
  - Throughput is 1 op per 2 cycles minimum.
- New input accepted the same edge ACCESS exits? No. IDLE is re-entered first; the next `in_valid` is accepted at the following edge.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
  - **Defined.** Misaligned half (`off[0]` = 1) or word (`off` != 0) access:
    - no bus request; stays IDLE.
    - `misalign_trap` pulses high for 1 cycle with the bubble (`reg_write` = 0).
  - **Undefined.** The port is absent; low offset bits are ignored:
    - half uses `off[1]` only.
    - word uses lane 0.

## Structure
- Package `mem_pkg`:
  - `mem_op` encodings (`MEM_LB` … `MEM_LHU`).
  - FSM state enum.
  - byte-enable base constants (`BE_BYTE` = 0001, `BE_HALF` = 0011, `BE_WORD` = 1111).
- Sub-module `load_align`: combinational `dmem_rdata` + `off` + `mem_op` → 32-bit extended load value. The stage instantiates it once.

## Test plan
- ALU pass-through: `alu_result` = 0x1234_5678, `rd_addr` = 5, `rd_write` = 1 → next cycle `reg_data` = 0x1234_5678, `reg_addr` = 5, `reg_write` = 1; with `rd_addr` = 0 → `reg_write` = 0.
- LB at 0x103, `dmem_rdata` = 0x80AB_CDEF, ack in first ACCESS cycle → `reg_data` = 0xFFFF_FF80; LBU → 0x0000_0080; `dmem_addr` = 0x100.
- SH at 0x102, `store_data` = 0x0000_BEEF → `dmem_wdata` = 0xBEEF_BEEF, `dmem_be` = 1100, `dmem_we` = 1, `reg_write` = 0.
- LW with `dmem_ack` delayed 3 cycles → `in_ready` low 4 cycles, `dmem_*` stable throughout, `reg_data` = `dmem_rdata` one edge after ack.
- Reset asserted mid-ACCESS → `dmem_req` = 0 immediately, `reg_write` stays 0, `in_ready` = 1; a late ack is ignored.
- LW at 0x101: with `MEM_MISALIGN_TRAP_EN` → `misalign_trap` 1-cycle pulse, no `dmem_req`; without → bus request at 0x100, `dmem_be` = 1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: mem_op codes, FSM states,
// access sizes and byte-enable base patterns.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LW  = 3'b010,
        MEM_LBU = 3'b100,
        MEM_LHU = 3'b101
    } mem_op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unused encodings (011, 110, 111) fall through to a word access.
    function automatic size_e op_size(input logic [2:0] op);
        size_e sz;
        case (op)
            MEM_LB, MEM_LBU: sz = SZ_BYTE;
            MEM_LH, MEM_LHU: sz = SZ_HALF;
            default:         sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == MEM_LB) || (op == MEM_LH);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half lane out of the
// bus word and sign- or zero-extends it according to mem_op.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    output logic [31:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        sext   = op_signed(op);
        case (op_size(op))
            SZ_BYTE: value = {{24{sext & byte_v[7]}}, byte_v};
            SZ_HALF: value = {{16{sext & half_v[15]}}, half_v};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: ALU pass-through plus single-outstanding
// load/store bus master. Optional misalignment trap via MEM_MISALIGN_TRAP_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic [2:0]            mem_op,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [4:0]            rd_addr,
    input  logic                  rd_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [31:0]           dmem_rdata,
    output logic [31:0]           reg_data,
    output logic [4:0]            reg_addr,
    output logic                  reg_write
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_trap
`endif
);

    state_e                state_q, state_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]           dmem_wdata_q, dmem_wdata_d;
    logic [3:0]            dmem_be_q, dmem_be_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            pend_rd_q, pend_rd_d;
    logic                  pend_wr_q, pend_wr_d;
    logic [31:0]           reg_data_q, reg_data_d;
    logic [4:0]            reg_addr_q, reg_addr_d;
    logic                  reg_write_q, reg_write_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                  trap_q, trap_d;
    logic                  misaligned;
`endif

    logic [ADDR_WIDTH-1:0] addr_full;
    logic [1:0]            off;
    logic                  wb_en;
    size_e                 sz;
    logic [31:0]           st_wdata;
    logic [3:0]            st_be;
    logic [31:0]           load_value;

    assign addr_full = ADDR_WIDTH'(alu_result);
    assign off       = alu_result[1:0];
    assign wb_en     = rd_write && (rd_addr != 5'd0);
    assign sz        = op_size(mem_op);

    // Narrow stores replicate the value across all lanes; byte enables pick the target.
    always_comb begin
        case (sz)
            SZ_BYTE: begin
                st_wdata = {4{store_data[7:0]}};
                st_be    = BE_BYTE << off;
            end
            SZ_HALF: begin
                st_wdata = {2{store_data[15:0]}};
                st_be    = BE_HALF << {off[1], 1'b0};
            end
            default: begin
                st_wdata = store_data;
                st_be    = BE_WORD;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
`endif

    load_align u_load_align (
        .rdata (dmem_rdata),
        .off   (off_q),
        .op    (op_q),
        .value (load_value)
    );

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        op_d         = op_q;
        off_d        = off_q;
        pend_rd_d    = pend_rd_q;
        pend_wr_d    = pend_wr_q;
        reg_data_d   = reg_data_q;
        reg_addr_d   = reg_addr_q;
        reg_write_d  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_read || mem_write) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            trap_d = 1'b1;
                        end else begin
`endif
                            state_d      = ACCESS;
                            dmem_req_d   = 1'b1;
                            dmem_we_d    = mem_write;
                            dmem_addr_d  = {addr_full[ADDR_WIDTH-1:2], 2'b00};
                            dmem_wdata_d = mem_write ? st_wdata : 32'd0;
                            dmem_be_d    = mem_write ? st_be : BE_WORD;
                            op_d         = mem_op;
                            off_d        = off;
                            pend_rd_d    = rd_addr;
                            pend_wr_d    = wb_en;
`ifdef MEM_MISALIGN_TRAP_EN
                        end
`endif
                    end else begin
                        reg_data_d  = alu_result;
                        reg_addr_d  = rd_addr;
                        reg_write_d = wb_en;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q) begin
                        reg_data_d  = load_value;
                        reg_addr_d  = pend_rd_q;
                        reg_write_d = pend_wr_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'd0;
            dmem_be_q    <= 4'd0;
            op_q         <= 3'd0;
            off_q        <= 2'd0;
            pend_rd_q    <= 5'd0;
            pend_wr_q    <= 1'b0;
            reg_data_q   <= 32'd0;
            reg_addr_q   <= 5'd0;
            reg_write_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            op_q         <= op_d;
            off_q        <= off_d;
            pend_rd_q    <= pend_rd_d;
            pend_wr_q    <= pend_wr_d;
            reg_data_q   <= reg_data_d;
            reg_addr_q   <= reg_addr_d;
            reg_write_q  <= reg_write_d;
`ifdef MEM_MISALIGN_TRAP_EN
            trap_q       <= trap_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;
    assign reg_data   = reg_data_q;
    assign reg_addr   = reg_addr_q;
    assign reg_write  = reg_write_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`endif

endmodule
